elevator_scan_ctrl: RTL and testbench



---
 rtl/elevator_pkg.sv | 28 ++
 rtl/elevator_tick_timer.sv | 43 ++++
 rtl/elevator_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Purpose: shared types and default constants for the SCAN elevator controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package elevator_pkg;

    // Encoding is visible on the fsm_state port, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int DEF_NUM_FLOORS   = 4;
    localparam int DEF_TRAVEL_TICKS = 2;
    localparam int DEF_DOOR_TICKS   = 3;

    // Counter width able to hold 0..ticks-1; never narrower than one bit.
    function automatic int tick_cnt_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Purpose: free-running tick counter 0..TERM_CNT while run is high, with sync clear.
// Latency: done is combinational from the count; it is high on the cycle holding TERM_CNT.
// Backpressure: none; the owner decides what to do with done.
//
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   run         count while high; the counter sits at 0 while low
//   clear       restart from 0 on the next edge (takes priority over counting)
//   done        run is high and the count is at TERM_CNT (count wraps to 0 next edge)
module elevator_tick_timer #(
    parameter int WIDTH    = 1,
    parameter int TERM_CNT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign done = run && (cnt_q == WIDTH'(TERM_CNT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run || done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Purpose: N-floor elevator controller serving latched calls in SCAN order.
// Latency: doors open one edge after a local call; TRAVEL_TICKS cycles per floor moved.
// Backpressure: none; calls are latched every cycle (except the current floor while doors are open).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low; discards all pending requests
//   call       one request bit per floor (level or single-cycle pulse)
//   up/down    motor drive, decoded from the MOVE_UP / MOVE_DOWN states
//   doors      doors open, decoded from DOOR_OPEN
//   floor      current or last-passed floor (registered)
//   fsm_state  IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3
//   pending    latched unserved requests
//
// Build option: define ELEVATOR_DOOR_REOPEN_EN so that a call for the current
// floor while the doors are open restarts the door timer.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int  NUM_FLOORS   = DEF_NUM_FLOORS,
    parameter int  TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter int  DOOR_TICKS   = DEF_DOOR_TICKS,
    localparam int FLOOR_W      = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call,
    output logic                  up,
    output logic                  down,
    output logic                  doors,
    output logic [FLOOR_W-1:0]    floor,
    output logic [1:0]            fsm_state,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int                 TRAVEL_W  = tick_cnt_width(TRAVEL_TICKS);
    localparam int                 DOOR_W    = tick_cnt_width(DOOR_TICKS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    state_t                state_q, state_d;
    dir_t                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;

    logic [NUM_FLOORS-1:0] req;
    logic                  above;
    logic                  below;
    logic                  travel_run;
    logic                  travel_done;
    logic                  door_run;
    logic                  door_done;
    logic                  door_reopen;

    // Any request strictly above / below floor f.
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] r,
                                       input logic [FLOOR_W-1:0]    f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) hit = hit | r[i];
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] r,
                                       input logic [FLOOR_W-1:0]    f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) hit = hit | r[i];
        end
        return hit;
    endfunction

    // A call raised this cycle counts immediately, so a request for the next
    // floor on the terminal travel cycle still stops the car there.
    assign req   = pending_q | call;
    assign above = any_above(req, floor_q);
    assign below = any_below(req, floor_q);

    assign travel_run = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN);
    assign door_run   = (state_q == ST_DOOR_OPEN);

`ifdef ELEVATOR_DOOR_REOPEN_EN
    assign door_reopen = door_run && call[floor_q];
`else
    assign door_reopen = 1'b0;
`endif

    elevator_tick_timer #(
        .WIDTH    (TRAVEL_W),
        .TERM_CNT (TRAVEL_TICKS - 1)
    ) u_travel_timer (
        .clk   (clk),
        .reset (reset),
        .run   (travel_run),
        .clear (1'b0),
        .done  (travel_done)
    );

    elevator_tick_timer #(
        .WIDTH    (DOOR_W),
        .TERM_CNT (DOOR_TICKS - 1)
    ) u_door_timer (
        .clk   (clk),
        .reset (reset),
        .run   (door_run),
        .clear (door_reopen),
        .done  (door_done)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        floor_d   = floor_q;
        pending_d = req;

        unique case (state_q)
            ST_IDLE: begin
                if (req[floor_q]) begin
                    state_d = ST_DOOR_OPEN;
                end else if ((dir_q == DIR_UP && above) ||
                             (dir_q == DIR_DOWN && !below && above)) begin
                    state_d = ST_MOVE_UP;
                    dir_d   = DIR_UP;
                end else if (below) begin
                    // Reached only when dir is DOWN, or dir is UP with nothing above.
                    state_d = ST_MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                end
            end

            ST_MOVE_UP: begin
                if (travel_done) begin
                    if (floor_q != TOP_FLOOR) floor_d = floor_q + FLOOR_W'(1);
                    if (req[floor_d]) begin
                        state_d = ST_DOOR_OPEN;
                    end else if (!any_above(req, floor_d)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_MOVE_DOWN: begin
                if (travel_done) begin
                    if (floor_q != '0) floor_d = floor_q - FLOOR_W'(1);
                    if (req[floor_d]) begin
                        state_d = ST_DOOR_OPEN;
                    end else if (!any_below(req, floor_d)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DOOR_OPEN: begin
                if (door_done && !door_reopen) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // The served floor is dropped on the entry edge (clear beats a
        // same-cycle call) and never latched while the doors are open,
        // including the closing cycle.
        if (state_d == ST_DOOR_OPEN || state_q == ST_DOOR_OPEN) begin
            pending_d[floor_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
        end
    end

    assign up        = (state_q == ST_MOVE_UP);
    assign down      = (state_q == ST_MOVE_DOWN);
    assign doors     = (state_q == ST_DOOR_OPEN);
    assign floor     = floor_q;
    assign fsm_state = state_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Purpose: directed self-checking bench for elevator_scan_ctrl (4 floors, 2 travel, 3 door ticks).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_elevator_scan_ctrl;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] call  = 4'b0000;
    logic       up;
    logic       down;
    logic       doors;
    logic [1:0] floor;
    logic [1:0] fsm_state;
    logic [3:0] pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS   (4),
        .TRAVEL_TICKS (2),
        .DOOR_TICKS   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call      (call),
        .up        (up),
        .down      (down),
        .doors     (doors),
        .floor     (floor),
        .fsm_state (fsm_state),
        .pending   (pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        call  = 4'b0000;
        #2;
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
        checks++; if (floor !== 2'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", floor); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        checks++; if ({up, down, doors} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b expected 000", {up, down, doors}); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_release_idle: got %0d expected 0", fsm_state); end
    endtask

    task automatic test_local_call();
        int door_cnt;
        int pend_seen;
        call = 4'b0001;
        tick();
        call = 4'b0000;
        checks++; if (doors !== 1'b1) begin errors++; $display("FAIL local_doors_rise: got %b expected 1", doors); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL local_pending_clear: got %b expected 0000", pending); end
        door_cnt  = 1;
        pend_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (doors === 1'b1) door_cnt++;
            if (pending[0] !== 1'b0) pend_seen = 1;
        end
        checks++; if (door_cnt != 3) begin errors++; $display("FAIL local_door_cycles: got %0d expected 3", door_cnt); end
        checks++; if (pend_seen != 0) begin errors++; $display("FAIL local_pending_never_set: got %0d expected 0", pend_seen); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL local_back_idle: got %0d expected 0", fsm_state); end
    endtask

    task automatic test_long_run();
        int         up_cnt;
        int         door_cnt;
        logic [1:0] floor_at [12];
        call = 4'b1000;
        tick();
        call = 4'b0000;
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL long_pending_latched: got %b expected 1000", pending); end
        up_cnt      = (up === 1'b1) ? 1 : 0;
        door_cnt    = (doors === 1'b1) ? 1 : 0;
        floor_at[0] = floor;
        for (int i = 1; i < 12; i++) begin
            tick();
            if (up === 1'b1) up_cnt++;
            if (doors === 1'b1) door_cnt++;
            floor_at[i] = floor;
        end
        checks++; if (up_cnt != 6) begin errors++; $display("FAIL long_up_cycles: got %0d expected 6", up_cnt); end
        checks++; if (floor_at[2] !== 2'd1) begin errors++; $display("FAIL long_floor1: got %0d expected 1", floor_at[2]); end
        checks++; if (floor_at[4] !== 2'd2) begin errors++; $display("FAIL long_floor2: got %0d expected 2", floor_at[4]); end
        checks++; if (floor_at[6] !== 2'd3) begin errors++; $display("FAIL long_floor3: got %0d expected 3", floor_at[6]); end
        checks++; if (door_cnt != 3) begin errors++; $display("FAIL long_door_cycles: got %0d expected 3", door_cnt); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL long_pending_empty: got %b expected 0000", pending); end
        checks++; if (floor !== 2'd3 || fsm_state !== 2'd0) begin errors++; $display("FAIL long_top_idle: got floor %0d state %0d expected floor 3 state 0", floor, fsm_state); end
    endtask

    task automatic test_scan_order();
        int   n_stops;
        int   stops [4];
        logic prev_doors;
        int   seen_down;
        int   up_after;
        // Return from floor 3 to floor 0 first.
        call = 4'b0001;
        tick();
        call = 4'b0000;
        repeat (9) tick();
        checks++; if (floor !== 2'd0 || fsm_state !== 2'd0) begin errors++; $display("FAIL scan_home: got floor %0d state %0d expected floor 0 state 0", floor, fsm_state); end
        call = 4'b1000;
        tick();
        call = 4'b0000;
        tick();
        tick();
        checks++; if (floor !== 2'd1 || up !== 1'b1) begin errors++; $display("FAIL scan_at_floor1: got floor %0d up %b expected floor 1 up 1", floor, up); end
        call = 4'b0101;
        tick();
        call = 4'b0000;
        checks++; if (pending !== 4'b1101) begin errors++; $display("FAIL scan_latched: got %b expected 1101", pending); end
        n_stops    = 0;
        prev_doors = doors;
        seen_down  = 0;
        up_after   = 0;
        for (int i = 0; i < 27; i++) begin
            tick();
            if (doors === 1'b1 && prev_doors !== 1'b1) begin
                if (n_stops < 4) stops[n_stops] = int'(floor);
                n_stops++;
            end
            prev_doors = doors;
            if (down === 1'b1) seen_down = 1;
            if (seen_down != 0 && up === 1'b1) up_after++;
        end
        checks++; if (n_stops != 3) begin errors++; $display("FAIL scan_stop_count: got %0d expected 3", n_stops); end
        else begin
            checks++; if (stops[0] != 2) begin errors++; $display("FAIL scan_stop0: got %0d expected 2", stops[0]); end
            checks++; if (stops[1] != 3) begin errors++; $display("FAIL scan_stop1: got %0d expected 3", stops[1]); end
            checks++; if (stops[2] != 0) begin errors++; $display("FAIL scan_stop2: got %0d expected 0", stops[2]); end
        end
        checks++; if (up_after != 0) begin errors++; $display("FAIL scan_no_up_after_reverse: got %0d expected 0", up_after); end
        checks++; if (pending !== 4'b0000 || fsm_state !== 2'd0) begin errors++; $display("FAIL scan_end: got pending %b state %0d expected 0000 / 0", pending, fsm_state); end
    endtask

    task automatic test_tie_break();
        int   n_stops;
        int   stops [4];
        logic prev_doors;
        call = 4'b0100;
        tick();
        call = 4'b0000;
        repeat (7) tick();
        checks++; if (floor !== 2'd2 || fsm_state !== 2'd0) begin errors++; $display("FAIL tie_at_floor2: got floor %0d state %0d expected floor 2 state 0", floor, fsm_state); end
        call = 4'b1010;
        tick();
        call = 4'b0000;
        checks++; if (up !== 1'b1 || down !== 1'b0) begin errors++; $display("FAIL tie_dir_wins: got up %b down %b expected up 1 down 0", up, down); end
        n_stops    = 0;
        prev_doors = doors;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (doors === 1'b1 && prev_doors !== 1'b1) begin
                if (n_stops < 4) stops[n_stops] = int'(floor);
                n_stops++;
            end
            prev_doors = doors;
        end
        checks++; if (n_stops != 2) begin errors++; $display("FAIL tie_stop_count: got %0d expected 2", n_stops); end
        else begin
            checks++; if (stops[0] != 3) begin errors++; $display("FAIL tie_stop0: got %0d expected 3", stops[0]); end
            checks++; if (stops[1] != 1) begin errors++; $display("FAIL tie_stop1: got %0d expected 1", stops[1]); end
        end
        checks++; if (floor !== 2'd1 || fsm_state !== 2'd0) begin errors++; $display("FAIL tie_end: got floor %0d state %0d expected floor 1 state 0", floor, fsm_state); end
    endtask

    task automatic test_door_reopen();
        int door_cnt;
        int exp_cnt;
`ifdef ELEVATOR_DOOR_REOPEN_EN
        exp_cnt = 5;
`else
        exp_cnt = 3;
`endif
        call = 4'b0010;
        tick();
        call = 4'b0000;
        door_cnt = (doors === 1'b1) ? 1 : 0;
        tick();
        if (doors === 1'b1) door_cnt++;
        call = 4'b0010;
        tick();
        call = 4'b0000;
        if (doors === 1'b1) door_cnt++;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (doors === 1'b1) door_cnt++;
        end
        checks++; if (door_cnt != exp_cnt) begin errors++; $display("FAIL reopen_door_cycles: got %0d expected %0d", door_cnt, exp_cnt); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reopen_pending: got %b expected 0000", pending); end
        checks++; if (fsm_state !== 2'd0 || floor !== 2'd1) begin errors++; $display("FAIL reopen_end: got state %0d floor %0d expected 0 / 1", fsm_state, floor); end
    endtask

    task automatic test_reset_mid();
        call = 4'b1000;
        tick();
        call = 4'b0000;
        tick();
        checks++; if (fsm_state !== 2'd1 || floor !== 2'd1) begin errors++; $display("FAIL rmid_moving: got state %0d floor %0d expected 1 / 1", fsm_state, floor); end
        reset = 1'b0;
        #1;
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rmid_state: got %0d expected 0", fsm_state); end
        checks++; if (floor !== 2'd0) begin errors++; $display("FAIL rmid_floor: got %0d expected 0", floor); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rmid_pending: got %b expected 0000", pending); end
        checks++; if ({up, down, doors} !== 3'b000) begin errors++; $display("FAIL rmid_outputs: got %b expected 000", {up, down, doors}); end
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (fsm_state !== 2'd0 || floor !== 2'd0) begin errors++; $display("FAIL rmid_held: got state %0d floor %0d expected 0 / 0", fsm_state, floor); end
        repeat (4) tick();
        checks++; if (fsm_state !== 2'd0 || up !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL rmid_discarded: got state %0d up %b pending %b expected 0 / 0 / 0000", fsm_state, up, pending); end
    endtask

    initial begin
        test_reset();
        test_local_call();
        test_long_run();
        test_scan_order();
        test_tie_break();
        test_door_reopen();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
